// File: rtl/demux_1to2_reg_pkg.sv
// Shared CPU package: the datapath width used by the demux.
// Only the width is shared; lane state stays local to the slot.
package demux_1to2_reg_pkg;

  localparam int unsigned XLEN = 32;

endpackage

// File: rtl/demux_1to2_reg_lane_slot.sv
// One-entry valid/data register for one demux lane.
// Load, drain and flush; data survives flush, valid does not.
module demux_lane_slot
  import demux_1to2_reg_pkg::*;
#(
  parameter int unsigned WIDTH = XLEN
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_flush,
  input  logic             i_load,
  input  logic [WIDTH-1:0] i_data,
  input  logic             i_ready,
  output logic             o_can_load,
  output logic             o_valid,
  output logic [WIDTH-1:0] o_data
);

  typedef enum logic {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } slot_e;

  slot_e            r_state;
  slot_e            w_state_nxt;
  logic [WIDTH-1:0] r_data;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state <= EMPTY;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Refill wins over drain so a full lane streams one word per cycle.
  always_comb begin
    w_state_nxt = r_state;
    if (i_flush) begin
      w_state_nxt = EMPTY;
    end else if (i_load) begin
      w_state_nxt = FULL;
    end else if (r_state == FULL && i_ready) begin
      w_state_nxt = EMPTY;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_data <= '0;
    end else if (i_load && !i_flush) begin
      r_data <= i_data;
    end
  end

  always_comb begin
    o_valid    = (r_state == FULL);
    o_can_load = (r_state == EMPTY) || i_ready;
    o_data     = r_data;
  end

endmodule

// File: rtl/demux_1to2_reg.sv
// Registered 1-to-2 demux with per-lane valid/ready handshakes.
// Lanes are independent; flush drops buffered words.
module demux_1to2_reg
  import demux_1to2_reg_pkg::*;
#(
  parameter int unsigned WIDTH = XLEN
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             flush_i,
  input  logic             valid_i,
  output logic             ready_o,
  input  logic             select_i,
  input  logic [WIDTH-1:0] data_i,
  output logic             valid0_o,
  input  logic             ready0_i,
  output logic [WIDTH-1:0] data0_o,
  output logic             valid1_o,
  input  logic             ready1_i,
  output logic [WIDTH-1:0] data1_o
);

  logic w_can0;
  logic w_can1;
  logic w_sel_can;
  logic w_xfer;
  logic w_load0;
  logic w_load1;

  always_comb begin
    w_sel_can = select_i ? w_can1 : w_can0;
    ready_o   = !rst_i && !flush_i && w_sel_can;
    w_xfer    = valid_i && ready_o;
    w_load0   = w_xfer && !select_i;
    w_load1   = w_xfer && select_i;
  end

  demux_lane_slot #(
    .WIDTH(WIDTH)
  ) u_lane0 (
    .i_clk     (clk_i),
    .i_rst     (rst_i),
    .i_flush   (flush_i),
    .i_load    (w_load0),
    .i_data    (data_i),
    .i_ready   (ready0_i),
    .o_can_load(w_can0),
    .o_valid   (valid0_o),
    .o_data    (data0_o)
  );

  demux_lane_slot #(
    .WIDTH(WIDTH)
  ) u_lane1 (
    .i_clk     (clk_i),
    .i_rst     (rst_i),
    .i_flush   (flush_i),
    .i_load    (w_load1),
    .i_data    (data_i),
    .i_ready   (ready1_i),
    .o_can_load(w_can1),
    .o_valid   (valid1_o),
    .o_data    (data1_o)
  );

endmodule
